// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes Diff = A - B one bit per clock, LSB first,
// with a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;
  logic             borrow;

  logic             d;
  logic             borrow_next;
  logic [WIDTH-1:0] sr_next;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d           = sa[0] ^ sb[0] ^ borrow;
    borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    sr_next     = {d, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      Diff   <= '0;
      Bout   <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      count  <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= A;
            sb     <= B;
            sr     <= '0;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sr     <= sr_next;
          sa     <= {1'b0, sa[WIDTH-1:1]};
          sb     <= {1'b0, sb[WIDTH-1:1]};
          borrow <= borrow_next;
          count  <= count + 1'b1;
          // Last bit: publish the full result including this cycle's bit.
          if (count == CW'(WIDTH - 1)) begin
            Diff  <= sr_next;
            Bout  <= borrow_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            count <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes Diff = A - B one bit per clock, LSB first, using a full-subtractor cell and a registered borrow.
- Trades latency for area versus the parallel adder/subtractor datapath.
- Sits behind the board switch/button input logic. Results drive the seven-segment/LED display path.
- Uses a start/busy/done handshake so a controller FSM can sequence operations.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- A  input  WIDTH  minuend; captured on the edge where start is accepted
- B  input  WIDTH  subtrahend; captured with A
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle pulse; Diff/Bout hold the new result
- Diff  output  WIDTH  registered difference (A - B) mod 2^WIDTH
- Bout  output  1  final borrow; 1 when A < B (unsigned)

Behaviour:
- Clock and reset:
  - One clock domain (clk). Reset is synchronous, active-high, and has priority over all other inputs.
  - Reset values: state=IDLE, busy=0, done=0, Diff=0, Bout=0, internal shift registers, borrow flop and bit counter = 0.
- State machine, three states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: latch A into sa, B into sb; borrow=0; count=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), at each edge E1..E_WIDTH:
  - a=sa[0], b=sb[0]
  - d = a ^ b ^ borrow
  - borrow_next = (~a & b) | (~(a ^ b) & borrow)
  - shift d into the MSB of the result shift register sr (shift right)
  - shift sa and sb right by one
  - count increments
- Completion at edge E_WIDTH (count reaches WIDTH-1 before that edge):
  - Diff <= final sr value, including this cycle's bit.
  - Bout <= borrow_next.
  - Go to DONE.
- DONE (busy=0): done=1 for exactly one cycle. Next edge returns to IDLE unconditionally.
- Latency:
  - done is high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the start-accept edge.
  - Minimum issue period is WIDTH+2 cycles (IDLE, WIDTH×SHIFT, DONE).
- Output holding:
  - Diff and Bout change only at the completion edge or on reset.
  - During SHIFT and IDLE they hold the previous result.
  - Partial results are never visible on Diff.
- start handling:
  - Ignored in SHIFT and DONE; no queuing.
  - If start stays high continuously, the next operation is accepted at the first IDLE edge after DONE, using the A/B present at that edge.
- Operand isolation: A/B changes after acceptance do not affect the running operation.
- Reset mid-operation: aborts the operation. No done pulse. Diff/Bout are cleared to 0. Returns to IDLE the cycle after.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - Bout=1 iff A<B.
  - For two's-complement use, Diff is the correct signed difference; overflow detection is not provided.
- Simultaneous reset and start: reset wins, start is ignored.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, pulse start → busy high 8 cycles; done pulses exactly 8 cycles after the accept edge; Diff=0x1E, Bout=0.
- A=0x00, B=0x01 → Diff=0xFF, Bout=1. Then A=0xFF, B=0xFF → Diff=0x00, Bout=0. Then A=0x80, B=0x7F → Diff=0x01, Bout=0.
- Start A=0x10, B=0x01; pulse start again with A=0x00, B=0x00 at cycle 3 of busy → ignored; result Diff=0x0F, Bout=0; exactly one done pulse.
- Complete 0x5A-0x3C (Diff=0x1E); start 0x00-0x01; sample Diff every SHIFT cycle → stays 0x1E until the completion edge, then 0xFF.
- Start 0x5A-0x3C; assert reset for one cycle at SHIFT cycle 4 → busy=0, done never pulses, Diff=0x00, Bout=0; a following start yields a correct result.
- Hold start=1 constantly with A=0x09, B=0x03 → done pulses every 10 cycles, each with Diff=0x06, Bout=0; repeat the same check with WIDTH=4 build (A=0x9, B=0x3 → 0x6, period 6).
